// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg : shared MEM-stage types and constants.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pipe_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10,
    FAULT_CONFLICT = 2'b11
  } mem_fault_t;

  localparam int c_default_timeout = 16;

endpackage : mips_pipe_pkg

`default_nettype wire

// File: rtl/mem_perf_counters.sv
// ---------------------------------------------------------------------------
// mem_perf_counters : wrapping load/store/stall event counters.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load_inc,
  input  logic        i_store_inc,
  input  logic        i_stall_inc,
  output logic [31:0] o_load_count,
  output logic [31:0] o_store_count,
  output logic [31:0] o_stall_count
);

  logic [31:0] r_load_count;
  logic [31:0] r_store_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_count  <= 32'd0;
      r_store_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (i_load_inc)  r_load_count  <= r_load_count  + 32'd1;
      if (i_store_inc) r_store_count <= r_store_count + 32'd1;
      if (i_stall_inc) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign o_load_count  = r_load_count;
  assign o_store_count = r_store_count;
  assign o_stall_count = r_stall_count;

endmodule : mem_perf_counters

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage : MIPS MEM stage - dmem handshake FSM, stall, MEM/WB reg.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_stage
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = c_default_timeout
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ULAout_in,
  input  logic [31:0] write_data_in,
  input  logic        zero_in,
  input  logic        branch_in,
  input  logic [31:0] pc_branch_in,
  input  logic [4:0]  write_reg_in,
  input  logic        regwrite_in,
  input  logic        memtoreg_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] pc_branch_out,
  output logic [31:0] readdata_out,
  output logic [31:0] ULAout_out,
  output logic [4:0]  write_reg_out,
  output logic        regwrite_out,
  output logic        memtoreg_out,
  output logic        wb_valid,
  output logic [1:0]  fault_out,
  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [31:0] stall_count
);

  localparam logic [7:0] c_timeout = 8'(TIMEOUT_CYCLES);

  mem_state_t  r_state;
  logic [7:0]  r_wait_cnt;

  logic        w_conflict;
  logic        w_mem_op;
  logic        w_misalign;
  logic        w_issue;
  logic        w_timed_out;
  logic        w_acked;
  logic        w_is_load;
  logic        w_is_store;
  mem_fault_t  w_fault;

  logic [31:0] r_readdata;
  logic [31:0] r_ulaout;
  logic [4:0]  r_write_reg;
  logic        r_regwrite;
  logic        r_memtoreg;
  logic        r_wb_valid;
  mem_fault_t  r_fault;

  assign w_conflict  = memread_in & memwrite_in;
  assign w_mem_op    = memread_in ^ memwrite_in;
  assign w_misalign  = w_mem_op & (ULAout_in[1:0] != 2'b00);
  assign w_issue     = w_mem_op & ~w_misalign;
  assign w_is_load   = memread_in & ~memwrite_in;
  assign w_is_store  = memwrite_in & ~memread_in;
  // Timeout fires on the WAIT cycle whose count equals the limit; that cycle
  // completes rather than stalls, giving TIMEOUT_CYCLES+1 stalled cycles.
  assign w_timed_out = (r_state == WAIT) && (r_wait_cnt == c_timeout);

  assign dmem_req   = ((r_state == IDLE) & w_issue) | (r_state == WAIT);
  assign dmem_we    = memwrite_in;
  assign dmem_addr  = ULAout_in;
  assign dmem_wdata = write_data_in;
  assign w_acked    = dmem_req & dmem_ack;

  assign stall = ((r_state == IDLE) & w_issue & ~dmem_ack) |
                 ((r_state == WAIT) & ~dmem_ack & ~w_timed_out);

  assign pcsrc         = branch_in & zero_in;
  assign pc_branch_out = pc_branch_in;

  always_comb begin
    w_fault = FAULT_NONE;
    if (w_conflict)
      w_fault = FAULT_CONFLICT;
    else if (w_misalign)
      w_fault = FAULT_MISALIGN;
    else if (w_timed_out && !dmem_ack)
      w_fault = FAULT_TIMEOUT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue && !dmem_ack) begin
            r_state    <= WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        WAIT: begin
          if (dmem_ack || w_timed_out) begin
            r_state    <= IDLE;
            r_wait_cnt <= 8'd0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stall) begin
      r_readdata  <= 32'd0;
      r_ulaout    <= 32'd0;
      r_write_reg <= 5'd0;
      r_regwrite  <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_fault     <= FAULT_NONE;
    end else begin
      r_readdata  <= (w_is_load && w_acked) ? dmem_rdata : 32'd0;
      r_ulaout    <= ULAout_in;
      r_write_reg <= write_reg_in;
      r_regwrite  <= regwrite_in & (w_fault == FAULT_NONE);
      r_memtoreg  <= memtoreg_in;
      r_wb_valid  <= 1'b1;
      r_fault     <= w_fault;
    end
  end

  assign readdata_out  = r_readdata;
  assign ULAout_out    = r_ulaout;
  assign write_reg_out = r_write_reg;
  assign regwrite_out  = r_regwrite;
  assign memtoreg_out  = r_memtoreg;
  assign wb_valid      = r_wb_valid;
  assign fault_out     = r_fault;

  mem_perf_counters u_perf (
    .clk           (clk),
    .rst           (reset),
    .i_load_inc    (w_acked & w_is_load),
    .i_store_inc   (w_acked & w_is_store),
    .i_stall_inc   (stall),
    .o_load_count  (load_count),
    .o_store_count (store_count),
    .o_stall_count (stall_count)
  );

endmodule : mem_access_stage

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage : directed checks of mem_access_stage, TIMEOUT_CYCLES=4.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ULAout_in, write_data_in, pc_branch_in, dmem_rdata;
  logic        zero_in, branch_in, regwrite_in, memtoreg_in, memread_in, memwrite_in;
  logic [4:0]  write_reg_in;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall, pcsrc;
  logic [31:0] dmem_addr, dmem_wdata, pc_branch_out, readdata_out, ULAout_out;
  logic [4:0]  write_reg_out;
  logic        regwrite_out, memtoreg_out, wb_valid;
  logic [1:0]  fault_out;
  logic [31:0] load_count, store_count, stall_count;

  int n_pass  = 0;
  int n_total = 0;
  int n_stall;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ULAout_in(ULAout_in), .write_data_in(write_data_in),
    .zero_in(zero_in), .branch_in(branch_in), .pc_branch_in(pc_branch_in),
    .write_reg_in(write_reg_in), .regwrite_in(regwrite_in),
    .memtoreg_in(memtoreg_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .pcsrc(pcsrc), .pc_branch_out(pc_branch_out),
    .readdata_out(readdata_out), .ULAout_out(ULAout_out),
    .write_reg_out(write_reg_out), .regwrite_out(regwrite_out),
    .memtoreg_out(memtoreg_out), .wb_valid(wb_valid), .fault_out(fault_out),
    .load_count(load_count), .store_count(store_count), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ULAout_in = 32'd0; write_data_in = 32'd0; pc_branch_in = 32'd0;
    zero_in = 1'b0; branch_in = 1'b0; write_reg_in = 5'd0;
    regwrite_in = 1'b0; memtoreg_in = 1'b0; memread_in = 1'b0; memwrite_in = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    step(); step();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_regwrite", regwrite_out, 0);
    chk("rst_fault", fault_out, 0);
    chk("rst_load_cnt", load_count, 0);
    chk("rst_stall_cnt", stall_count, 0);
    chk("rst_req", dmem_req, 0);

    // ALU op plus branch resolution
    reset = 1'b0;
    ULAout_in = 32'h10; regwrite_in = 1'b1; write_reg_in = 5'd5;
    branch_in = 1'b1; zero_in = 1'b1; pc_branch_in = 32'h400;
    #1;
    chk("alu_req", dmem_req, 0);
    chk("alu_stall", stall, 0);
    chk("br_pcsrc", pcsrc, 1);
    chk("br_target", pc_branch_out, 32'h400);
    zero_in = 1'b0;
    #1;
    chk("br_not_taken", pcsrc, 0);
    step();
    chk("alu_ulaout", ULAout_out, 32'h10);
    chk("alu_wreg", write_reg_out, 5);
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_regwrite", regwrite_out, 1);

    // Load from 0x100, ack 3 cycles after issue
    idle_inputs();
    ULAout_in = 32'h100; memread_in = 1'b1; regwrite_in = 1'b1;
    memtoreg_in = 1'b1; write_reg_in = 5'd8;
    #1;
    chk("ld_req", dmem_req, 1);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_we", dmem_we, 0);
    chk("ld_stall_c0", stall, 1);
    step();
    chk("ld_stall_c1", stall, 1);
    chk("ld_bubble", wb_valid, 0);
    step();
    chk("ld_stall_c2", stall, 1);
    chk("ld_req_held", dmem_req, 1);
    step();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_stall_ack", stall, 0);
    step();
    chk("ld_rdata", readdata_out, 32'hDEADBEEF);
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_regwrite", regwrite_out, 1);
    chk("ld_memtoreg", memtoreg_out, 1);
    chk("ld_count", load_count, 1);
    chk("ld_stall_cnt", stall_count, 3);

    // Store to 0x204 with same-cycle ack
    idle_inputs();
    ULAout_in = 32'h204; write_data_in = 32'hA5A5A5A5; memwrite_in = 1'b1;
    dmem_ack = 1'b1;
    #1;
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("st_stall", stall, 0);
    step();
    chk("st_count", store_count, 1);
    chk("st_regwrite", regwrite_out, 0);
    chk("st_wb_valid", wb_valid, 1);
    chk("st_rdata", readdata_out, 0);
    chk("st_stall_cnt", stall_count, 3);

    // Misaligned load
    idle_inputs();
    ULAout_in = 32'h102; memread_in = 1'b1; regwrite_in = 1'b1;
    #1;
    chk("mis_req", dmem_req, 0);
    chk("mis_stall", stall, 0);
    step();
    chk("mis_fault", fault_out, 2'b01);
    chk("mis_regwrite", regwrite_out, 0);
    chk("mis_wb_valid", wb_valid, 1);

    // Read/write conflict
    idle_inputs();
    ULAout_in = 32'h200; memread_in = 1'b1; memwrite_in = 1'b1; regwrite_in = 1'b1;
    #1;
    chk("cf_req", dmem_req, 0);
    step();
    chk("cf_fault", fault_out, 2'b11);
    chk("cf_regwrite", regwrite_out, 0);

    // Load that never acks: expect TIMEOUT_CYCLES+1 = 5 stalled cycles
    idle_inputs();
    ULAout_in = 32'h300; memread_in = 1'b1; regwrite_in = 1'b1;
    #1;
    n_stall = 0;
    for (int i = 0; i < 20 && stall; i++) begin
      n_stall++;
      step();
    end
    chk("to_stall_cycles", n_stall, 5);
    chk("to_req_final", dmem_req, 1);
    step();
    chk("to_fault", fault_out, 2'b10);
    chk("to_regwrite", regwrite_out, 0);
    chk("to_wb_valid", wb_valid, 1);
    idle_inputs();
    #1;
    chk("to_req_drop", dmem_req, 0);
    chk("to_load_cnt", load_count, 1);
    chk("to_stall_cnt", stall_count, 8);

    // Reset during second WAIT cycle, late ack afterwards
    ULAout_in = 32'h400; memread_in = 1'b1; regwrite_in = 1'b1;
    step();
    step();
    chk("rw_stall", stall, 1);
    reset = 1'b1;
    step();
    chk("rw_wb_valid", wb_valid, 0);
    chk("rw_regwrite", regwrite_out, 0);
    chk("rw_fault", fault_out, 0);
    chk("rw_load_cnt", load_count, 0);
    chk("rw_stall_cnt", stall_count, 0);
    reset = 1'b0;
    idle_inputs();
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    chk("rw_req", dmem_req, 0);
    chk("rw_late_stall", stall, 0);
    step();
    chk("rw_late_load", load_count, 0);
    chk("rw_late_store", store_count, 0);
    chk("rw_late_stallc", stall_count, 0);
    chk("rw_late_rdata", readdata_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_access_stage

`default_nettype wire
